// File: rtl/scratchmem_arb2.sv
// Two-master Wishbone arbiter for the 128-bit scratchpad: round-robin grants held
// for the whole cycle, a forced idle gap between owners, and a per-grant ack watchdog.
module scratchmem_arb2 #(
    parameter int TIMEOUT = 64,
    parameter int GAP     = 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,

    input  logic         m0_cyc_i,
    input  logic         m0_stb_i,
    input  logic         m0_we_i,
    input  logic [2:0]   m0_cti_i,
    input  logic [15:0]  m0_sel_i,
    input  logic [15:0]  m0_adr_i,
    input  logic [127:0] m0_dat_i,
    output logic         m0_ack_o,
    output logic         m0_err_o,

    input  logic         m1_cyc_i,
    input  logic         m1_stb_i,
    input  logic         m1_we_i,
    input  logic [2:0]   m1_cti_i,
    input  logic [15:0]  m1_sel_i,
    input  logic [15:0]  m1_adr_i,
    input  logic [127:0] m1_dat_i,
    output logic         m1_ack_o,
    output logic         m1_err_o,

    output logic         s_cs_o,
    output logic         s_cyc_o,
    output logic         s_stb_o,
    output logic         s_we_o,
    output logic [2:0]   s_cti_o,
    output logic [15:0]  s_sel_o,
    output logic [15:0]  s_adr_o,
    output logic [127:0] s_dat_o,
    input  logic         s_ack_i,
    input  logic [127:0] s_dat_i,

    output logic [127:0] m_dat_o,
    output logic [1:0]   owner_o
);

    localparam int GAP_EFF = (GAP < 1) ? 1 : GAP;
    localparam int TW      = ($clog2(TIMEOUT + 1) < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam int GW      = $clog2(GAP_EFF + 1);

    localparam logic [TW-1:0] WD_LAST  = TW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam logic [TW-1:0] WD_MAX   = TW'(TIMEOUT);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_EFF - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_OWN0,
        ST_OWN1,
        ST_GAP,
        ST_ABT0,
        ST_ABT1
    } state_t;

    state_t        state;
    logic          ptr;      // master that wins when both request
    logic [TW-1:0] wd_cnt;
    logic [GW-1:0] gap_cnt;

    logic          own0, own1, owned;
    logic          req0, req1;
    logic          x_cyc, x_stb, x_we;
    logic [2:0]    x_cti;
    logic [15:0]   x_sel, x_adr;
    logic [127:0]  x_dat;
    logic          wd_fire, drive;

    assign own0  = (state == ST_OWN0);
    assign own1  = (state == ST_OWN1);
    assign owned = own0 | own1;
    assign req0  = m0_cyc_i & m0_stb_i;
    assign req1  = m1_cyc_i & m1_stb_i;

    always_comb begin
        x_cyc = m0_cyc_i;
        x_stb = m0_stb_i;
        x_we  = m0_we_i;
        x_cti = m0_cti_i;
        x_sel = m0_sel_i;
        x_adr = m0_adr_i;
        x_dat = m0_dat_i;
        if (own1) begin
            x_cyc = m1_cyc_i;
            x_stb = m1_stb_i;
            x_we  = m1_we_i;
            x_cti = m1_cti_i;
            x_sel = m1_sel_i;
            x_adr = m1_adr_i;
            x_dat = m1_dat_i;
        end
    end

    // An ack in the final wait cycle beats the timeout.
    assign wd_fire = (TIMEOUT != 0) && owned && x_cyc && x_stb && !s_ack_i
                     && (wd_cnt == WD_LAST);
    assign drive   = owned && !wd_fire;

    assign s_cyc_o = drive & x_cyc;
    assign s_cs_o  = drive & x_cyc;
    assign s_stb_o = drive & x_stb;
    assign s_we_o  = drive & x_we;
    assign s_cti_o = drive ? x_cti : 3'b000;
    assign s_sel_o = drive ? x_sel : 16'h0000;
    assign s_adr_o = drive ? x_adr : 16'h0000;
    assign s_dat_o = drive ? x_dat : '0;

    assign m_dat_o  = owned ? s_dat_i : '0;
    assign m0_ack_o = own0 & s_ack_i;
    assign m1_ack_o = own1 & s_ack_i;
    assign m0_err_o = own0 & wd_fire;
    assign m1_err_o = own1 & wd_fire;
    assign owner_o  = {own1, own0};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= ST_IDLE;
            ptr     <= 1'b0;
            wd_cnt  <= '0;
            gap_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    wd_cnt <= '0;
                    if (req0 && req1) begin
                        state <= ptr ? ST_OWN1 : ST_OWN0;
                    end else if (req0) begin
                        state <= ST_OWN0;
                    end else if (req1) begin
                        state <= ST_OWN1;
                    end
                end
                ST_OWN0, ST_OWN1: begin
                    // Only a dropped cyc ends ownership, so bursts are never split.
                    if (!x_cyc) begin
                        state   <= ST_GAP;
                        ptr     <= own0;
                        gap_cnt <= '0;
                    end else if (wd_fire) begin
                        state <= own0 ? ST_ABT0 : ST_ABT1;
                        ptr   <= own0;
                    end else if (s_ack_i) begin
                        wd_cnt <= '0;
                    end else if (x_stb && (TIMEOUT != 0) && (wd_cnt != WD_MAX)) begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                ST_ABT0: begin
                    if (!m0_cyc_i) begin
                        state   <= ST_GAP;
                        gap_cnt <= '0;
                    end
                end
                ST_ABT1: begin
                    if (!m1_cyc_i) begin
                        state   <= ST_GAP;
                        gap_cnt <= '0;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_scratchmem_arb2.sv
// Bench for scratchmem_arb2: vector table, directed corner sequences and random
// traffic, all checked every cycle against a behavioural ownership model.
module tb_scratchmem_arb2;

    localparam int TO = 64;
    localparam int GP = 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         m0_cyc = 0, m0_stb = 0, m0_we = 0;
    logic [2:0]   m0_cti = 0;
    logic [15:0]  m0_sel = 0, m0_adr = 0;
    logic [127:0] m0_dat = 0;
    logic         m1_cyc = 0, m1_stb = 0, m1_we = 0;
    logic [2:0]   m1_cti = 0;
    logic [15:0]  m1_sel = 0, m1_adr = 0;
    logic [127:0] m1_dat = 0;
    logic         s_ack = 0;
    logic [127:0] s_dat = 0;

    logic         m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
    logic         s_cs_o, s_cyc_o, s_stb_o, s_we_o;
    logic [2:0]   s_cti_o;
    logic [15:0]  s_sel_o, s_adr_o;
    logic [127:0] s_dat_o, m_dat_o;
    logic [1:0]   owner_o;

    always #5 clk = ~clk;

    scratchmem_arb2 #(.TIMEOUT(TO), .GAP(GP)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_cti_i(m0_cti),
        .m0_sel_i(m0_sel), .m0_adr_i(m0_adr), .m0_dat_i(m0_dat),
        .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_cti_i(m1_cti),
        .m1_sel_i(m1_sel), .m1_adr_i(m1_adr), .m1_dat_i(m1_dat),
        .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .s_cs_o(s_cs_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_cti_o(s_cti_o), .s_sel_o(s_sel_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
        .s_ack_i(s_ack), .s_dat_i(s_dat),
        .m_dat_o(m_dat_o), .owner_o(owner_o)
    );

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void chk(string nm, logic [127:0] act, logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic void chk1(string nm, logic act, logic exp);
        chk(nm, 128'(act), 128'(exp));
    endfunction

    // Reference model: who owns the slave, whether that ownership was aborted,
    // remaining gap cycles, round-robin preference and unacked strobe cycles.
    int mo    = -1;
    bit mab   = 0;
    int mgap  = 0;
    int mptr  = 0;
    int mwait = 0;

    task automatic mdl_reset();
        mo = -1; mab = 0; mgap = 0; mptr = 0; mwait = 0;
    endtask

    function automatic bit mdl_fire();
        bit c = (mo == 1) ? m1_cyc : m0_cyc;
        bit s = (mo == 1) ? m1_stb : m0_stb;
        return (mo >= 0) && !mab && (TO > 0) && c && s && !s_ack && (mwait + 1 >= TO);
    endfunction

    task automatic mdl_check();
        bit g, c, s, w, fire, drv;
        logic [2:0] ct;
        logic [15:0] sl, ad;
        logic [127:0] dt;
        logic [1:0] eo;
        g    = (mo >= 0) && !mab;
        c    = (mo == 1) ? m1_cyc : m0_cyc;
        s    = (mo == 1) ? m1_stb : m0_stb;
        w    = (mo == 1) ? m1_we  : m0_we;
        ct   = (mo == 1) ? m1_cti : m0_cti;
        sl   = (mo == 1) ? m1_sel : m0_sel;
        ad   = (mo == 1) ? m1_adr : m0_adr;
        dt   = (mo == 1) ? m1_dat : m0_dat;
        fire = mdl_fire();
        drv  = g && !fire;
        eo   = !g ? 2'b00 : ((mo == 0) ? 2'b01 : 2'b10);
        chk1("mdl_s_cyc", s_cyc_o, drv & c);
        chk1("mdl_s_cs", s_cs_o, drv & c);
        chk1("mdl_s_stb", s_stb_o, drv & s);
        chk1("mdl_s_we", s_we_o, drv & w);
        chk("mdl_s_cti", 128'(s_cti_o), 128'(drv ? ct : 3'b000));
        chk("mdl_s_sel", 128'(s_sel_o), 128'(drv ? sl : 16'h0));
        chk("mdl_s_adr", 128'(s_adr_o), 128'(drv ? ad : 16'h0));
        chk("mdl_s_dat", s_dat_o, drv ? dt : 128'h0);
        chk("mdl_m_dat", m_dat_o, g ? s_dat : 128'h0);
        chk1("mdl_m0_ack", m0_ack_o, g && mo == 0 && s_ack);
        chk1("mdl_m1_ack", m1_ack_o, g && mo == 1 && s_ack);
        chk1("mdl_m0_err", m0_err_o, fire && mo == 0);
        chk1("mdl_m1_err", m1_err_o, fire && mo == 1);
        chk("mdl_owner", 128'(owner_o), 128'(eo));
    endtask

    task automatic mdl_step();
        bit c, s, fire;
        c    = (mo == 1) ? m1_cyc : m0_cyc;
        s    = (mo == 1) ? m1_stb : m0_stb;
        fire = mdl_fire();
        if (mgap > 0) begin
            mgap--;
        end else if (mo < 0) begin
            if ((m0_cyc && m0_stb) && (m1_cyc && m1_stb)) mo = mptr;
            else if (m0_cyc && m0_stb) mo = 0;
            else if (m1_cyc && m1_stb) mo = 1;
            mwait = 0;
        end else if (mab) begin
            if (!c) begin mo = -1; mab = 0; mgap = GP; end
        end else if (!c) begin
            mptr = 1 - mo; mo = -1; mgap = GP;
        end else if (fire) begin
            mab = 1; mptr = 1 - mo;
        end else if (s_ack) begin
            mwait = 0;
        end else if (s) begin
            mwait++;
        end
    endtask

    task automatic sample();
        @(negedge clk);
        if (!rst_n) mdl_reset();
        mdl_check();
    endtask

    task automatic adv();
        if (rst_n) mdl_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(int n);
        for (int i = 0; i < n; i++) begin sample(); adv(); end
    endtask

    typedef struct {
        bit c0, s0, c1, s1, ack;
        logic [1:0] owner;
        bit scyc, a0, a1;
    } vec_t;

    vec_t tbl[13];
    logic [2:0] ctis[3];
    bit hang;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        ctis[0] = 3'b000; ctis[1] = 3'b010; ctis[2] = 3'b111;
        //            c0 s0 c1 s1 ack owner  scyc a0 a1
        tbl[0]  = '{1, 1, 1, 1, 0, 2'b00, 0, 0, 0};
        tbl[1]  = '{1, 1, 1, 1, 1, 2'b01, 1, 1, 0};
        tbl[2]  = '{0, 0, 1, 1, 0, 2'b01, 0, 0, 0};
        tbl[3]  = '{1, 1, 1, 1, 0, 2'b00, 0, 0, 0};
        tbl[4]  = '{1, 1, 1, 1, 0, 2'b00, 0, 0, 0};
        tbl[5]  = '{1, 1, 1, 1, 1, 2'b10, 1, 0, 1};
        tbl[6]  = '{1, 1, 0, 0, 0, 2'b10, 0, 0, 0};
        tbl[7]  = '{1, 1, 0, 0, 0, 2'b00, 0, 0, 0};
        tbl[8]  = '{1, 1, 0, 0, 0, 2'b00, 0, 0, 0};
        tbl[9]  = '{1, 1, 0, 0, 1, 2'b01, 1, 1, 0};
        tbl[10] = '{0, 0, 0, 0, 0, 2'b01, 0, 0, 0};
        tbl[11] = '{0, 0, 0, 0, 0, 2'b00, 0, 0, 0};
        tbl[12] = '{0, 0, 0, 0, 0, 2'b00, 0, 0, 0};

        // Initial reset with a master requesting and the slave acking.
        m0_cyc = 1; m0_stb = 1; s_ack = 1; s_dat = {4{32'hA5A5_5A5A}};
        for (int i = 0; i < 2; i++) begin
            sample();
            chk1("rst_s_cyc", s_cyc_o, 0);
            chk1("rst_s_cs", s_cs_o, 0);
            chk1("rst_m0_ack", m0_ack_o, 0);
            chk("rst_owner", 128'(owner_o), 128'(2'b00));
            chk("rst_m_dat", m_dat_o, 128'h0);
            adv();
        end
        m0_cyc = 0; m0_stb = 0; s_ack = 0;
        rst_n = 1;

        // Single classic write from M0.
        m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_cti = 3'b000;
        m0_adr = 16'h0010; m0_sel = 16'hFFFF;
        m0_dat = 128'h112233445566778899AABBCCDDEEFF;
        sample(); chk1("wr_req_s_cyc", s_cyc_o, 0); adv();
        sample();
        chk1("wr_own_s_cyc", s_cyc_o, 1);
        chk("wr_own_s_adr", 128'(s_adr_o), 128'(16'h0010));
        chk("wr_own_s_sel", 128'(s_sel_o), 128'(16'hFFFF));
        chk("wr_own_s_dat", s_dat_o, 128'h112233445566778899AABBCCDDEEFF);
        chk1("wr_own_s_we", s_we_o, 1);
        chk1("wr_noack", m0_ack_o, 0);
        adv();
        s_ack = 1;
        sample(); chk1("wr_ack", m0_ack_o, 1); adv();
        s_ack = 0; m0_cyc = 0; m0_stb = 0;
        sample(); chk1("wr_rel_s_cyc", s_cyc_o, 0); adv();
        sample(); chk1("wr_gap_s_cyc", s_cyc_o, 0);
        chk("wr_gap_owner", 128'(owner_o), 128'(2'b00)); adv();
        idle_cycles(1);

        // Reset asserted mid-way through an M0 write.
        m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_adr = 16'h0020;
        sample(); adv();
        sample(); chk("mid_own_owner", 128'(owner_o), 128'(2'b01)); adv();
        s_ack = 1;
        #2;
        rst_n = 0;
        #1;
        chk1("midrst_s_cyc", s_cyc_o, 0);
        chk1("midrst_m0_ack", m0_ack_o, 0);
        chk("midrst_owner", 128'(owner_o), 128'(2'b00));
        sample(); adv();
        m0_cyc = 0; m0_stb = 0; s_ack = 0;
        sample(); adv();
        rst_n = 1;

        // Joint requests and round-robin, driven from the vector table.
        m0_we = 1; m0_adr = 16'h0100; m1_we = 0; m1_adr = 16'h0200;
        for (int i = 0; i < 13; i++) begin
            m0_cyc = tbl[i].c0; m0_stb = tbl[i].s0;
            m1_cyc = tbl[i].c1; m1_stb = tbl[i].s1;
            s_ack  = tbl[i].ack;
            sample();
            chk($sformatf("tbl%0d_owner", i), 128'(owner_o), 128'(tbl[i].owner));
            chk1($sformatf("tbl%0d_s_cyc", i), s_cyc_o, tbl[i].scyc);
            chk1($sformatf("tbl%0d_m0_ack", i), m0_ack_o, tbl[i].a0);
            chk1($sformatf("tbl%0d_m1_ack", i), m1_ack_o, tbl[i].a1);
            adv();
        end

        // M0 five-beat incrementing burst read; M1 requests from beat 2.
        m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_cti = 3'b010; m0_adr = 16'h0040;
        sample(); adv();
        for (int k = 1; k <= 5; k++) begin
            m0_cti = (k == 5) ? 3'b111 : 3'b010;
            s_ack = 1; s_dat = {4{32'(k)}};
            if (k >= 2) begin m1_cyc = 1; m1_stb = 1; end
            sample();
            chk("burst_owner", 128'(owner_o), 128'(2'b01));
            chk1("burst_m0_ack", m0_ack_o, 1);
            chk1("burst_m1_ack", m1_ack_o, 0);
            chk("burst_s_cti", 128'(s_cti_o), 128'(m0_cti));
            adv();
            m0_adr = m0_adr + 16'h0010;
        end
        m0_cyc = 0; m0_stb = 0; m0_cti = 3'b000; s_ack = 0;
        sample(); chk1("burst_rel_m1_ack", m1_ack_o, 0); adv();
        sample(); chk("burst_gap_owner", 128'(owner_o), 128'(2'b00)); adv();
        sample(); chk("burst_idle_owner", 128'(owner_o), 128'(2'b00)); adv();
        sample(); chk("burst_m1_owner", 128'(owner_o), 128'(2'b10));
        chk1("burst_m1_s_cyc", s_cyc_o, 1); adv();
        m1_cyc = 0; m1_stb = 0;
        idle_cycles(3);

        // Slave never acks: watchdog aborts M0, pending M1 follows.
        m0_cyc = 1; m0_stb = 1; m0_we = 1; m1_cyc = 1; m1_stb = 1;
        sample(); adv();
        for (int k = 1; k <= TO; k++) begin
            sample();
            if (k < TO) begin
                if (k == 1 || k == TO - 1) begin
                    chk1($sformatf("wd_wait%0d_err", k), m0_err_o, 0);
                    chk1($sformatf("wd_wait%0d_s_cyc", k), s_cyc_o, 1);
                end
            end else begin
                chk1("wd_fire_err", m0_err_o, 1);
                chk1("wd_fire_s_cyc", s_cyc_o, 0);
                chk1("wd_fire_s_stb", s_stb_o, 0);
                chk1("wd_fire_m0_ack", m0_ack_o, 0);
            end
            adv();
        end
        for (int k = 0; k < 3; k++) begin
            s_ack = (k == 1);
            sample();
            chk1("abort_s_cyc", s_cyc_o, 0);
            chk1("abort_m0_err", m0_err_o, 0);
            chk1("abort_m0_ack", m0_ack_o, 0);
            chk("abort_owner", 128'(owner_o), 128'(2'b00));
            adv();
        end
        s_ack = 0; m0_cyc = 0; m0_stb = 0;
        idle_cycles(3);
        sample(); chk("wd_m1_owner", 128'(owner_o), 128'(2'b10));
        chk1("wd_m1_s_cyc", s_cyc_o, 1); adv();
        m1_cyc = 0; m1_stb = 0;
        idle_cycles(3);

        // Ack lands on the last wait cycle: ack wins, ownership continues.
        m0_cyc = 1; m0_stb = 1;
        sample(); adv();
        for (int k = 1; k < TO; k++) begin sample(); adv(); end
        s_ack = 1;
        sample();
        chk1("late_ack_ack", m0_ack_o, 1);
        chk1("late_ack_err", m0_err_o, 0);
        chk1("late_ack_s_cyc", s_cyc_o, 1);
        adv();
        s_ack = 0;
        for (int k = 0; k < 10; k++) begin
            sample();
            chk("late_ack_owner", 128'(owner_o), 128'(2'b01));
            chk1("late_ack_noerr", m0_err_o, 0);
            adv();
        end
        m0_cyc = 0; m0_stb = 0;
        idle_cycles(3);

        // Random traffic, including hung-slave stretches and stray resets.
        hang = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 0) hang = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, hang ? 150 : 12) == 0) m0_cyc = ~m0_cyc;
            if ($urandom_range(0, hang ? 150 : 12) == 0) m1_cyc = ~m1_cyc;
            m0_stb = m0_cyc & ($urandom_range(0, 3) != 0);
            m1_stb = m1_cyc & ($urandom_range(0, 3) != 0);
            m0_we = 1'($urandom); m1_we = 1'($urandom);
            m0_cti = ctis[$urandom_range(0, 2)]; m1_cti = ctis[$urandom_range(0, 2)];
            m0_sel = 16'($urandom); m1_sel = 16'($urandom);
            m0_adr = 16'($urandom); m1_adr = 16'($urandom);
            m0_dat = {$urandom, $urandom, $urandom, $urandom};
            m1_dat = {$urandom, $urandom, $urandom, $urandom};
            s_dat  = {$urandom, $urandom, $urandom, $urandom};
            s_ack  = hang ? 1'b0 : ($urandom_range(0, 2) == 0);
            rst_n  = ($urandom_range(0, 700) != 0);
            sample(); adv();
        end
        rst_n = 1; m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0; s_ack = 0;
        idle_cycles(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/scratchmem_arb2.md
Name: scratchmem_arb2

Overview:
- Two-master Wishbone arbiter in front of the 128-bit scratchpad memory (16-bit byte address, 16 byte selects).
- Shares the single slave port between M0 (CPU data port) and M1 (DMA/debug port).
- Grants are round-robin, held for the whole cycle (including cti bursts), with a forced idle gap between grants so the slave sees a fresh rising select.
- A watchdog breaks a hung ownership and returns an error to the stalled master.

Parameters:
- TIMEOUT, 64: cycles a granted cycle may wait without slave ack before abort; 0 disables the watchdog.
- GAP, 1: idle cycles inserted between release and next grant (minimum 1).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  M0 bus cycle, strobe, write
- m0_cti_i  in  3  M0 cycle type (000 classic, 010 incr burst, 111 end)
- m0_sel_i  in  16  M0 byte selects
- m0_adr_i  in  16  M0 byte address
- m0_dat_i  in  128  M0 write data
- m0_ack_o, m0_err_o  out  1 each  M0 ack; M0 watchdog abort
- m1_*  same set as m0_*, for M1
- s_cs_o, s_cyc_o, s_stb_o, s_we_o  out  1 each  to slave
- s_cti_o  out  3  to slave
- s_sel_o  out  16  to slave
- s_adr_o  out  16  to slave
- s_dat_o  out  128  to slave
- s_ack_i  in  1  slave ack
- s_dat_i  in  128  slave read data
- m_dat_o  out  128  read data, shared by both masters
- owner_o  out  2  debug: 00 none, 01 M0, 10 M1

Behaviour:
- Reset (async assert, sync release). State IDLE, owner none, priority pointer = M0, watchdog = 0, gap counter = 0.
  - All s_* outputs are 0 during reset, as are m*_ack_o, m*_err_o, owner_o and m_dat_o.
- FSM states: IDLE, OWN0, OWN1, GAP.
  - IDLE: requester = cyc&stb.
    - One requester: grant it next cycle.
    - Both requesting: grant the one named by the pointer.
    - Grant takes effect on the clock edge, so there is one cycle from request to s_cyc_o.
  - OWNx: slave signals are a combinational mux of master x, with s_cs_o = s_cyc_o = mx_cyc_i.
    - mx_ack_o = s_ack_i; the other master's ack and err are 0.
    - m_dat_o = s_dat_i unconditionally; masters qualify it with ack.
  - Leaving OWNx:
    - Normal exit when mx_cyc_i = 0 at a clock edge. The next state is GAP and the pointer moves to the other master.
    - An in-progress burst (cti 010) keeps ownership until cyc drops, regardless of the other master's requests.
  - GAP: all s_* are 0 for GAP cycles, then IDLE. This guarantees a low cs cycle between owners, which the slave's edge detector and burst counter require.
- Watchdog:
  - In OWNx, the counter increments each cycle with stb high and no s_ack_i. It clears on ack or on state entry.
  - When the count reaches TIMEOUT:
    - mx_err_o pulses for one cycle, and all s_* are 0 that cycle.
    - The FSM moves to ABORT-wait: it stays out of OWNx (slave signals 0) until mx_cyc_i drops, then goes to GAP.
    - The pointer moves to the other master.
- Simultaneous events:
  - Release and new request in the same cycle: the new request is not granted until after GAP.
  - If s_ack_i coincides with the timeout cycle, the ack wins: it is passed through and the counter clears.
  - The same master re-requesting after GAP with no competitor is granted again, and the pointer stays on the other master.
- Reset mid-cycle: all outputs drop immediately (asynchronously). No partial slave write is gated by the arbiter; masters retry after reset.
- Widths: the watchdog counter is clog2(TIMEOUT+1) bits and saturates. The GAP counter is clog2(GAP+1) bits.

Test Plan:
- Reset mid-OWN0 write (rst_ni low for 2 cycles): s_cyc_o, m0_ack_o and owner_o are 0 within the same cycle; after release, state is IDLE and the next simultaneous request goes to M0.
- Single M0 classic write, adr 0x0010, sel 0xFFFF, dat 0x1122..FF: s_cyc_o rises 1 cycle after request, and m0_ack_o mirrors s_ack_i. After cyc drops, s_cyc_o is 0 for 1 cycle (GAP=1) and owner_o returns to 00.
- M0 and M1 request together from reset: M0 is served first, M1 next after the 1-cycle gap. A second joint request grants M1 first (round-robin).
- M0 5-beat burst read (cti 010 ×4, 111), with M1 requesting from beat 2: M1 gets no grant until M0 drops cyc; m1_ack_o stays 0 throughout; the M1 grant follows the gap.
- Slave never acks with TIMEOUT=64: m0_err_o pulses at cycle 64 of stb-high, s_cyc_o drops that cycle, and a pending M1 is granted after M0 drops cyc plus the gap.
- s_ack_i arrives on exactly the 64th wait cycle: m0_ack_o=1, m0_err_o=0, and ownership continues.
